// File: rtl/grid_io_cfg_bank.sv
// grid_io_cfg_bank: edge IO tile; per-pad dir/oreg bits loaded over the ccff chain, pads gated by cfg_done.
// Latency: pad_in->fabric_in SYNC_STAGES cycles; fabric_out->pad_out 0 cycles (comb) or 1 cycle (oreg).
// Backpressure: none; optional GRID_IO_LOOPBACK_EN adds a loopback port that routes output pads back to fabric.
module grid_io_cfg_bank #(
    parameter int NUM_PADS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CFG_BITS    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
`ifdef GRID_IO_LOOPBACK_EN
    input  logic                loopback,
`endif
    input  logic                ccff_en,
    input  logic                ccff_head,
    output logic                ccff_tail,
    output logic                cfg_done,
    input  logic [NUM_PADS-1:0] gfpga_pad_in,
    output logic [NUM_PADS-1:0] gfpga_pad_out,
    output logic [NUM_PADS-1:0] gfpga_pad_oe,
    output logic [NUM_PADS-1:0] fabric_in,
    input  logic [NUM_PADS-1:0] fabric_out
);
    localparam int L  = NUM_PADS * CFG_BITS;
    localparam int CW = $clog2(L + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(L);

    logic [L-1:0]        cfg;
    logic [CW-1:0]       cnt;
    logic                en_q;
    logic [NUM_PADS-1:0] q;
    logic [NUM_PADS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PADS-1:0] dir;
    logic [NUM_PADS-1:0] oreg;
    logic [NUM_PADS-1:0] out_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg  <= '0;
            cnt  <= '0;
            en_q <= 1'b0;
        end else begin
            en_q <= ccff_en;
            if (ccff_en) begin
                cfg <= {cfg[L-2:0], ccff_head};
            end
            // cnt only reaches CNT_FULL after an unbroken run of at least L shifts
            if (ccff_en && !en_q) begin
                cnt <= CW'(1);
            end else if (ccff_en) begin
                cnt <= (cnt == CNT_FULL) ? CNT_FULL : cnt + CW'(1);
            end else if (en_q && cnt != CNT_FULL) begin
                cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            q         <= fabric_out;
            sync_q[0] <= gfpga_pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        dir  = '0;
        oreg = '0;
        for (int i = 0; i < NUM_PADS; i++) begin
            dir[i]  = cfg[CFG_BITS*i];
            oreg[i] = cfg[CFG_BITS*i+1];
        end
    end

    assign ccff_tail = cfg[L-1];
    assign cfg_done  = (cnt == CNT_FULL) && !ccff_en;
    assign out_sel   = (oreg & q) | (~oreg & fabric_out);

`ifdef GRID_IO_LOOPBACK_EN
    // Loopback taps the pre-gating output value, since pad_oe is forced low in loopback.
    logic [NUM_PADS-1:0] lb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lb_q <= '0;
        end else begin
            lb_q <= out_sel & dir;
        end
    end

    assign gfpga_pad_oe  = {NUM_PADS{cfg_done && !loopback}} & dir;
    assign gfpga_pad_out = gfpga_pad_oe & out_sel;
    assign fabric_in     = {NUM_PADS{cfg_done}} &
                           ((~dir & sync_q[SYNC_STAGES-1]) | ({NUM_PADS{loopback}} & dir & lb_q));
`else
    assign gfpga_pad_oe  = {NUM_PADS{cfg_done}} & dir;
    assign gfpga_pad_out = gfpga_pad_oe & out_sel;
    assign fabric_in     = {NUM_PADS{cfg_done}} & ~dir & sync_q[SYNC_STAGES-1];
`endif

endmodule
